div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the EX stage of the 5-stage MIPS core.
- Consumes operand_1 (dividend) and operand_2 (divisor) as produced by ID operand generation and carried through ID/EX.
- Serves DIV/DIVU; quotient goes to LO and remainder to HI.
- EX holds the pipeline stall request while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (matches DATA_BUS).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request a division; sampled only in IDLE or DONE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start.
- cancel  input  1  pipeline flush; aborts any operation.
- operand_1  input  WIDTH  dividend, latched with start.
- operand_2  input  WIDTH  divisor, latched with start.
- busy  output  1  high while a division is in progress (stall request to EX).
- done  output  1  one-cycle pulse; results valid in the same cycle.
- quotient  output  WIDTH  LO result; held until next accepted start.
- remainder  output  WIDTH  HI result; held until next accepted start.
- div_by_zero  output  1  set with done when the latched divisor was 0.

Behaviour:
- Reset (rst=0 at an edge): state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; counter cleared. Reset overrides cancel and start.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1, cancel=0, divisor!=0:
  - Latch |operand_1| and |operand_2|. Magnitude is taken only when signed_div=1 and the MSB is 1.
  - Latch sign_q = op1[MSB]^op2[MSB] and sign_r = op1[MSB] (both forced 0 when signed_div=0).
  - Clear partial remainder, clear counter, go to RUN.
- IDLE/DONE + start=1, cancel=0, divisor==0:
  - Go to DONE next cycle.
  - quotient = all ones, remainder = operand_1 unmodified, div_by_zero = 1.
- RUN, each cycle:
  - Shift {partial_rem, dividend} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
  - Counter increments.
  - After exactly WIDTH RUN cycles, go to DONE.
- Entering DONE:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r (two's-complement negate, WIDTH bits, wrap).
  - div_by_zero = 0 for the non-zero-divisor path.
- DONE: done=1 for exactly this cycle. Without a new start, the next state is IDLE and results are held.
- Latency (non-zero divisor): start sampled at edge N → busy=1 from N+1 through N+WIDTH → done=1 in cycle N+WIDTH+1.
- busy is 1 only in RUN; it is 0 in IDLE and DONE.
- start while in RUN: ignored; latched operands are unchanged.
- start while in DONE: accepted as a back-to-back operation. done is still 1 in that cycle; the new operation proceeds as from IDLE.
- cancel=1 in any state:
  - Next state IDLE; busy=0 and done=0 next cycle.
  - quotient/remainder retain their previous completed values.
  - cancel has priority over start in the same cycle.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, no flag.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- DIV_EARLY_OUT_EN defined:
  - At start with a non-zero divisor, if |dividend| < |divisor| (unsigned compare of magnitudes), skip RUN and go to DONE next cycle (done at N+1).
  - Results in that case: quotient = 0, remainder = operand_1 unmodified.
- DIV_EARLY_OUT_EN undefined: every non-zero-divisor operation takes the full WIDTH RUN cycles.
- The numeric results are identical either way.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles, then release → busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Unsigned division: start, DIVU 100/7 → busy for 32 cycles; done in cycle 33 after start; quotient=14, remainder=2.
- Signed division: DIV -7/2 (0xFFFFFFF9/2) → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). DIV 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Divide by zero: DIVU 5/0 → done at N+1, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5.
- Cancel: start DIVU 100/7, assert cancel at RUN cycle 10 → busy=0 next cycle, no done pulse, prior results kept. start+cancel in the same cycle → stays IDLE.
- Back-to-back and early out:
  - Assert start in the DONE cycle with DIVU 9/3 → busy next cycle, second done carries quotient=3, remainder=0.
  - start during RUN is ignored.
  - With DIV_EARLY_OUT_EN defined, DIVU 3/9 → done at N+1, quotient=0, remainder=3.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [WIDTH-1:0] dvd_r, dvs_r, prem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_q_r, sign_r_r;

  logic             zero_s, early_s, last_s, qbit_s;
  logic [WIDTH-1:0] mag1_s, mag2_s, next_rem_s, next_dvd_s;
  logic [WIDTH:0]   shifted_s, trial_s;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
    mag = (en && v[WIDTH-1]) ? neg(v) : v;
  endfunction

  assign zero_s = (operand_2 == ZERO);
  assign mag1_s = mag(operand_1, signed_div);
  assign mag2_s = mag(operand_2, signed_div);
  assign last_s = (cnt_r == LAST);

`ifdef DIV_EARLY_OUT_EN
  assign early_s = (mag1_s < mag2_s);
`else
  assign early_s = 1'b0;
`endif

  // The trial subtract is one bit wider than the operands, so its MSB is the borrow.
  assign shifted_s  = {prem_r, dvd_r[WIDTH-1]};
  assign trial_s    = shifted_s - {1'b0, dvs_r};
  assign qbit_s     = ~trial_s[WIDTH];
  assign next_rem_s = qbit_s ? trial_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
  assign next_dvd_s = {dvd_r[WIDTH-2:0], qbit_s};

  // Next-state selection; cancel wins over everything except reset.
  always_comb begin
    state_s = state_r;
    if (cancel) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_s = (zero_s || early_s) ? DONE : RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == RUN);
      done    <= (state_s == DONE);
    end
  end

  // Operand latching, shift/subtract iteration and result write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dvd_r       <= ZERO;
      dvs_r       <= ZERO;
      prem_r      <= ZERO;
      cnt_r       <= {CNT_W{1'b0}};
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      quotient    <= ZERO;
      remainder   <= ZERO;
      div_by_zero <= 1'b0;
    end else if (!cancel) begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            sign_q_r <= signed_div & (operand_1[WIDTH-1] ^ operand_2[WIDTH-1]);
            sign_r_r <= signed_div & operand_1[WIDTH-1];
            dvd_r    <= mag1_s;
            dvs_r    <= mag2_s;
            prem_r   <= ZERO;
            cnt_r    <= {CNT_W{1'b0}};
            if (zero_s) begin
              quotient    <= ONES;
              remainder   <= operand_1;
              div_by_zero <= 1'b1;
            end else if (early_s) begin
              quotient    <= ZERO;
              remainder   <= operand_1;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd_r  <= next_dvd_s;
          prem_r <= next_rem_s;
          cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_s) begin
            quotient    <= sign_q_r ? neg(next_dvd_s) : next_dvd_s;
            remainder   <= sign_r_r ? neg(next_rem_s) : next_rem_s;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random operands
// checked against an arithmetic reference model.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, signed_div, cancel;
  logic [WIDTH-1:0] operand_1, operand_2;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_q, exp_r, prev_q, prev_r;
  logic             exp_z;
  int               exp_lat;

  div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .cancel(cancel),
    .operand_1(operand_1), .operand_2(operand_2), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended 64-bit values.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, ma, mb;
    operand_1  = a;
    operand_2  = b;
    signed_div = s;
    start      = 1'b1;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (b == 32'd0) begin
      exp_q = 32'hFFFF_FFFF; exp_r = a; exp_z = 1'b1; exp_lat = 1;
    end else begin
      exp_q = 32'(sa / sb); exp_r = 32'(sa % sb); exp_z = 1'b0; exp_lat = WIDTH + 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) exp_lat = 1;
`endif
    end
  endtask

  // Walk the operation to its done cycle; optionally poke start mid-run.
  task automatic complete(input string tag, input int inject_k);
    for (int k = 1; k <= exp_lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k < exp_lat) begin
        check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
        if (k == inject_k) begin
          start     = 1'b1;
          operand_1 = $urandom;
          operand_2 = $urandom_range(1, 50);
        end
      end else begin
        check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
      end
    end
    prev_q = exp_q;
    prev_r = exp_r;
  endtask

  initial begin
    logic saw;
    logic [31:0] a, b;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0;
    operand_1 = 32'd0; operand_2 = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_flags", {29'd0, busy, done, div_by_zero}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);

    issue(32'd100, 32'd7, 1'b0);            complete("divu_100_7", 0);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("held_q", quotient, 32'd14);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);      complete("div_m7_2", 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); complete("div_ovf", 0);
    issue(32'd5, 32'd0, 1'b0);              complete("divu_5_0", 0);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1);      complete("div_m5_0", 0);
    issue(32'd3, 32'd9, 1'b0);              complete("divu_3_9", 0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);      complete("div_7_m2", 0);

    // Cancel in the tenth RUN cycle: no done, previous results kept.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("cancel_prebusy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_flags", {30'd0, busy, done}, 32'd0);
    check("cancel_q", quotient, prev_q);
    check("cancel_r", remainder, prev_r);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw = saw | done | busy;
    end
    check("cancel_quiet", {31'd0, saw}, 32'd0);

    // Start and cancel together: stays idle.
    operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("startcancel_flags", {30'd0, busy, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("startcancel_idle", {30'd0, busy, done}, 32'd0);
    check("startcancel_q", quotient, prev_q);

    // Back-to-back from the DONE cycle, then start ignored during RUN.
    issue(32'd1000, 32'd3, 1'b0);           complete("b2b_first", 0);
    issue(32'd9, 32'd3, 1'b0);              complete("b2b_second", 0);
    issue(32'd12345, 32'd17, 1'b0);         complete("run_start_ignored", 5);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
      issue(a, b, 1'($urandom_range(0, 1)));
      complete("rand", 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
